rr_arb_mux_4b_8to1: RTL and testbench

Round-robin scheduler that shares one 8:1 4-bit mux datapath among eight requesters.
- Each cycle it picks one valid requester, steers that requester's data through the mux, and captures the result in a one-entry registered output stage.
- The downstream side uses a val/rdy handshake.
- Sits between eight independent producers and a single 4-bit consumer port.

---
 rtl/rr_arb_mux_pkg.sv | 14 +
 rtl/rr_arb_8.sv | 41 ++++
 rtl/rr_arb_mux_4b_8to1.sv | 102 ++++++++++
 tb/tb_rr_arb_mux_4b_8to1.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and sizes for the round-robin 8:1 arbitrated mux.
//   NUM_REQ   - number of requesters sharing the datapath
//   SEL_BITS  - width of a requester index
//   sel_t     - requester index / priority pointer
//   req_vec_t - one bit per requester (valid / ready vectors)
package rr_arb_mux_pkg;

  localparam int NUM_REQ  = 8;
  localparam int SEL_BITS = 3;

  typedef logic [SEL_BITS-1:0] sel_t;
  typedef logic [NUM_REQ-1:0]  req_vec_t;

endpackage

// File: rtl/rr_arb_8.sv
// Combinational 8-way round-robin arbiter.
// Ports:
//   reqs    - request vector, bit i = requester i wants service
//   ptr     - index of the requester with highest priority this cycle
//   gnt_val - at least one request is present
//   gnt_idx - winning requester (first request at or after ptr, wrapping)
// The request vector is rotated so that ptr lands on bit 0, a fixed
// lowest-index-first search picks the winner, and the result is rotated
// back by adding ptr (the 3-bit add wraps 7->0 naturally).
module rr_arb_8
  import rr_arb_mux_pkg::*;
(
  input  req_vec_t reqs,
  input  sel_t     ptr,
  output logic     gnt_val,
  output sel_t     gnt_idx
);

  req_vec_t rot;
  sel_t     first;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      // Index arithmetic is 3 bits wide, so it wraps modulo 8.
      assign rot[gi] = reqs[sel_t'(gi) + ptr];
    end
  endgenerate

  always_comb begin
    first = '0;
    // Scan downward so the lowest set bit is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = sel_t'(i);
    end
  end

  assign gnt_val = |reqs;
  assign gnt_idx = first + ptr;

endmodule

// File: rtl/rr_arb_mux_4b_8to1.sv
// Round-robin scheduler sharing one 8:1 mux among eight requesters, with a
// one-entry registered output stage on a val/rdy handshake.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   in_val[7:0]     - requester i has valid data on in<i>
//   in_rdy[7:0]     - one-hot (or zero) acceptance of the winning requester
//   in0 .. in7      - requester data, p_nbits each
//   out_val         - output register holds valid data
//   out_rdy         - consumer takes out this cycle
//   out_sel         - index of the requester whose data is in out
//   out             - registered mux output
module rr_arb_mux_4b_8to1
  import rr_arb_mux_pkg::*;
#(
  parameter int p_nbits = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_val,
  output logic [7:0]         in_rdy,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  input  logic [p_nbits-1:0] in4,
  input  logic [p_nbits-1:0] in5,
  input  logic [p_nbits-1:0] in6,
  input  logic [p_nbits-1:0] in7,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [2:0]         out_sel,
  output logic [p_nbits-1:0] out
);

  logic [p_nbits-1:0] in_arr [NUM_REQ];
  logic [p_nbits-1:0] mux_out;

  logic [p_nbits-1:0] out_reg;
  sel_t               out_sel_reg;
  logic               out_val_reg;
  sel_t               ptr_reg;
  sel_t               ptr_next;

  logic gnt_val;
  sel_t gnt_idx;
  logic free;
  logic grant;

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;
  assign in_arr[6] = in6;
  assign in_arr[7] = in7;

  rr_arb_8 u_arb (
    .reqs    (in_val),
    .ptr     (ptr_reg),
    .gnt_val (gnt_val),
    .gnt_idx (gnt_idx)
  );

  assign mux_out  = in_arr[gnt_idx];
  assign ptr_next = gnt_idx + sel_t'(1);

  // The stage can take new data when empty or when it drains this cycle,
  // which is what makes back-to-back transfers bubble-free.
  assign free  = !out_val_reg || out_rdy;
  assign grant = free && !reset && gnt_val;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
      assign in_rdy[gi] = grant && (gnt_idx == sel_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg     <= '0;
      out_sel_reg <= '0;
      out_val_reg <= 1'b0;
      ptr_reg     <= '0;
    end else if (grant) begin
      out_reg     <= mux_out;
      out_sel_reg <= gnt_idx;
      out_val_reg <= 1'b1;
      ptr_reg     <= ptr_next;
    end else if (free) begin
      // Drained (or already empty) with nothing to load: data, index and
      // pointer are left as they were.
      out_val_reg <= 1'b0;
    end
  end

  assign out     = out_reg;
  assign out_sel = out_sel_reg;
  assign out_val = out_val_reg;

endmodule

// File: tb/tb_rr_arb_mux_4b_8to1.sv
module tb_rr_arb_mux_4b_8to1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_val;
  logic [7:0] in_rdy;
  logic [3:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic       out_val;
  logic       out_rdy;
  logic [2:0] out_sel;
  logic [3:0] out;

  int checks   = 0;
  int failures = 0;

  // Expected transfers: {sel[2:0], data[3:0]}
  logic [6:0] sb [$];

  always #5 clk = ~clk;

  rr_arb_mux_4b_8to1 #(.p_nbits(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .in5     (in5),
    .in6     (in6),
    .in7     (in7),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_sel (out_sel),
    .out     (out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output transfer is popped and compared.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_val === 1'b1 && out_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xfer_unexpected sel=%0d out=%0h expected=none", out_sel, out);
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        check("xfer_sel", {29'd0, out_sel}, {29'd0, e[6:4]});
        check("xfer_out", {28'd0, out}, {28'd0, e[3:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_rdy;
    reset  = 1'b1;
    in_val = 8'hFF;
    out_rdy = 1'b1;
    in0 = 4'h0; in1 = 4'h1; in2 = 4'h2; in3 = 4'h3;
    in4 = 4'h4; in5 = 4'h5; in6 = 4'h6; in7 = 4'h7;

    // Reset held two cycles with every requester asking.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("reset_in_rdy", {24'd0, in_rdy}, 32'h0);
      check("reset_out_val", {31'd0, out_val}, 32'h0);
    end
    reset = 1'b0;

    // Full contention: 0..7 then 0..5, leaving ptr at 6.
    for (int k = 0; k < 14; k++) begin
      #1;
      exp_rdy = 8'h01 << (k % 8);
      check("contend_in_rdy", {24'd0, in_rdy}, {24'd0, exp_rdy});
      sb.push_back({3'(k % 8), 4'(k % 8)});
      tick();
    end
    check("ptr_after_5", {29'd0, dut.ptr_reg}, 32'd6);

    // Sparse wrap: only 0 and 1 request with ptr=6.
    in_val = 8'b0000_0011;
    #1;
    check("wrap_rdy0", {24'd0, in_rdy}, 32'h01);
    sb.push_back({3'd0, 4'h0});
    tick();
    check("wrap_ptr1", {29'd0, dut.ptr_reg}, 32'd1);
    check("wrap_rdy1", {24'd0, in_rdy}, 32'h02);
    sb.push_back({3'd1, 4'h1});
    tick();
    check("wrap_ptr2", {29'd0, dut.ptr_reg}, 32'd2);

    // Load requester 3, then stall the output for three cycles.
    in_val = 8'h08;
    sb.push_back({3'd3, 4'h3});
    tick();
    out_rdy = 1'b0;
    in_val  = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_rdy", {24'd0, in_rdy}, 32'h0);
      check("stall_out_val", {31'd0, out_val}, 32'h1);
      check("stall_out_sel", {29'd0, out_sel}, 32'd3);
      check("stall_out", {28'd0, out}, 32'h3);
      check("stall_ptr", {29'd0, dut.ptr_reg}, 32'd4);
      tick();
    end
    // Drain of 3 and grant of 4 in the same cycle.
    out_rdy = 1'b1;
    #1;
    check("drain_grant_rdy", {24'd0, in_rdy}, 32'h10);
    sb.push_back({3'd4, 4'h4});
    tick();

    // Idle gap: single request from 5, then nothing.
    in5    = 4'hA;
    in_val = 8'h20;
    sb.push_back({3'd5, 4'hA});
    tick();
    in_val = 8'h00;
    tick();
    check("idle_out_val", {31'd0, out_val}, 32'h0);
    check("idle_ptr", {29'd0, dut.ptr_reg}, 32'd6);
    check("idle_out_sel_hold", {29'd0, out_sel}, 32'd5);
    check("idle_out_hold", {28'd0, out}, 32'hA);

    // Reset while stalled: held data must be discarded.
    in0     = 4'hC;
    in_val  = 8'h01;
    out_rdy = 1'b0;
    tick();
    check("pre_reset_out_val", {31'd0, out_val}, 32'h1);
    check("pre_reset_out", {28'd0, out}, 32'hC);
    reset = 1'b1;
    #1;
    check("reset_mid_in_rdy", {24'd0, in_rdy}, 32'h0);
    tick();
    check("rst_out_val", {31'd0, out_val}, 32'h0);
    check("rst_out", {28'd0, out}, 32'h0);
    check("rst_out_sel", {29'd0, out_sel}, 32'd0);
    check("rst_ptr", {29'd0, dut.ptr_reg}, 32'd0);

    // After reset requester 0 has priority again.
    reset   = 1'b0;
    out_rdy = 1'b1;
    in_val  = 8'hFF;
    #1;
    check("post_reset_rdy", {24'd0, in_rdy}, 32'h01);
    sb.push_back({3'd0, 4'hC});
    tick();
    in_val = 8'h00;
    tick();
    tick();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
